// File: rtl/f1_resp_checker.sv
// Stimulus/response checker for a 4-input combinational function: walks {a,b,c,d} through
// codes 0..15, samples f1 after a settle window and compares it against EXPECTED.
module f1_resp_checker #(
  parameter logic [15:0] EXPECTED      = 16'h0000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f1,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        first_err_valid,
  output logic [3:0]  first_err_idx,
  output logic [15:0] captured
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  settle_q, settle_d;
  logic [3:0]  stim_q, stim_d;
  logic [4:0]  err_q, err_d;
  logic        fev_q, fev_d;
  logic [3:0]  fei_q, fei_d;
  logic [15:0] cap_q, cap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      settle_q <= 8'd0;
      stim_q   <= 4'd0;
      err_q    <= 5'd0;
      fev_q    <= 1'b0;
      fei_q    <= 4'd0;
      cap_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      stim_q   <= stim_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fei_q    <= fei_d;
      cap_q    <= cap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    stim_d   = stim_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fei_d    = fei_q;
    cap_d    = cap_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StSettle;
          idx_d    = 4'd0;
          settle_d = 8'd0;
          stim_d   = 4'd0;
          err_d    = 5'd0;
          fev_d    = 1'b0;
          fei_d    = 4'd0;
          cap_d    = 16'd0;
        end
      end
      StSettle: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        cap_d[idx_q] = f1;
        if (f1 != EXPECTED[idx_q]) begin
          err_d = err_q + 5'd1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end
        end
        // Code 15 finishes the run; the stimulus parks at all-ones while done.
        if (idx_q == 4'd15) begin
          state_d = StDone;
          stim_d  = 4'hF;
        end else begin
          state_d  = StSettle;
          idx_d    = idx_q + 4'd1;
          stim_d   = idx_q + 4'd1;
          settle_d = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign {a, b, c, d}    = stim_q;
  assign busy            = (state_q == StSettle) || (state_q == StSample);
  assign done            = (state_q == StDone);
  assign pass            = done && (err_q == 5'd0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign captured        = cap_q;

endmodule

// File: tb/tb_f1_resp_checker.sv
// Directed bench for f1_resp_checker: one instance at SETTLE_CYCLES=4 and one at
// SETTLE_CYCLES=1, each answered by a table-driven model of the function under test.
module tb_f1_resp_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Instance with default settle time
  logic        start4 = 1'b0;
  logic        a4, b4, c4, d4, f14, busy4, done4, pass4, fev4;
  logic [4:0]  err4;
  logic [3:0]  fei4;
  logic [15:0] cap4;
  logic [15:0] model4 = 16'hA5C3;
  assign f14 = model4[{a4, b4, c4, d4}];

  f1_resp_checker #(.EXPECTED(16'hA5C3), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .c(c4), .d(d4), .f1(f14),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_err_valid(fev4), .first_err_idx(fei4), .captured(cap4)
  );

  // Instance with minimum settle time
  logic        start1 = 1'b0;
  logic        a1, b1, c1, d1, f11, busy1, done1, pass1, fev1;
  logic [4:0]  err1;
  logic [3:0]  fei1;
  logic [15:0] cap1;
  logic [15:0] model1 = 16'h1234;
  assign f11 = model1[{a1, b1, c1, d1}];

  f1_resp_checker #(.EXPECTED(16'h1234), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .f1(f11),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_idx(fei1), .captured(cap1)
  );

  logic [26:0] got, want;

  // Full run on dut4 with stimulus/timing checks; optionally pokes start at codes 3 and 9.
  task automatic run4(input bit pulse_busy);
    @(negedge clk) start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({a4, b4, c4, d4} !== 4'(i) || busy4 !== 1'b1 || done4 !== 1'b0 || pass4 !== 1'b0) begin
        bad++;
        $display("FAIL run4_code%0d: abcd=%h busy=%b done=%b pass=%b, want abcd=%h busy=1 done=0 pass=0",
                 i, {a4, b4, c4, d4}, busy4, done4, pass4, 4'(i));
      end
      if (i == 15) begin
        repeat (4) @(posedge clk);
      end else if (pulse_busy && (i == 3 || i == 9)) begin
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (4) @(posedge clk);
      end else begin
        repeat (5) @(posedge clk);
      end
      #1;
    end
    total++;
    if (done4 !== 1'b0 || busy4 !== 1'b1) begin
      bad++;
      $display("FAIL run4_done_early: done=%b busy=%b at start+80, want done=0 busy=1", done4, busy4);
    end
    @(posedge clk);
    #1;
    total++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || {a4, b4, c4, d4} !== 4'hF) begin
      bad++;
      $display("FAIL run4_done_time: done=%b busy=%b abcd=%h at start+81, want done=1 busy=0 abcd=f",
               done4, busy4, {a4, b4, c4, d4});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    got = {pass4, err4, fev4, fei4, cap4};
    if (got !== 27'd0 || {a4, b4, c4, d4} !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut4: res=%h abcd=%h busy=%b done=%b, want all zero",
               got, {a4, b4, c4, d4}, busy4, done4);
    end
    total++;
    if ({pass1, err1, fev1, fei1, cap1, busy1, done1, a1, b1, c1, d1} !== 33'd0) begin
      bad++;
      $display("FAIL reset_dut1: outputs=%h, want 0",
               {pass1, err1, fev1, fei1, cap1, busy1, done1, a1, b1, c1, d1});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_match();
    model4 = 16'hA5C3;
    run4(1'b0);
    got  = {pass4, err4, fev4, fei4, cap4};
    want = {1'b1, 5'd0, 1'b0, 4'd0, 16'hA5C3};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL match_results: got %h want %h", got, want);
    end
    repeat (5) @(posedge clk);
    #1;
    got = {pass4, err4, fev4, fei4, cap4};
    total++;
    if (got !== want || done4 !== 1'b1) begin
      bad++;
      $display("FAIL match_hold: got %h done=%b want %h done=1", got, done4, want);
    end
  endtask

  task automatic test_single_mismatch();
    model4 = 16'hA5C3 ^ 16'h0020;
    run4(1'b0);
    got  = {pass4, err4, fev4, fei4, cap4};
    want = {1'b0, 5'd1, 1'b1, 4'd5, 16'hA5E3};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL single_mismatch: got %h want %h", got, want);
    end
  endtask

  task automatic test_all_mismatch();
    model4 = ~16'hA5C3;
    run4(1'b0);
    got  = {pass4, err4, fev4, fei4, cap4};
    want = {1'b0, 5'd16, 1'b1, 4'd0, 16'h5A3C};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL all_mismatch: got %h want %h", got, want);
    end
  endtask

  task automatic test_start_while_busy();
    model4 = 16'hA5C3 ^ 16'h0400;
    run4(1'b1);
    got  = {pass4, err4, fev4, fei4, cap4};
    want = {1'b0, 5'd1, 1'b1, 4'd10, 16'hA1C3};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL start_while_busy: got %h want %h", got, want);
    end
  endtask

  task automatic test_reset_mid_run();
    model4 = ~16'hA5C3;
    @(negedge clk) start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    got  = {pass4, err4, fev4, fei4, cap4};
    want = {1'b0, 5'd7, 1'b1, 4'd0, 16'h003C};
    total++;
    if (got !== want || {a4, b4, c4, d4} !== 4'd7) begin
      bad++;
      $display("FAIL midrun_partial: got %h abcd=%h want %h abcd=7", got, {a4, b4, c4, d4}, want);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {pass4, err4, fev4, fei4, cap4};
    total++;
    if (got !== 27'd0 || {a4, b4, c4, d4} !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL midrun_async_reset: res=%h abcd=%h busy=%b done=%b, want all zero",
               got, {a4, b4, c4, d4}, busy4, done4);
    end
    @(negedge clk) rst_n = 1'b1;
    model4 = 16'hA5C3;
    run4(1'b0);
    got  = {pass4, err4, fev4, fei4, cap4};
    want = {1'b1, 5'd0, 1'b0, 4'd0, 16'hA5C3};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL midrun_rerun: got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    model1 = 16'h1234 ^ 16'h8001;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    got  = {pass1, err1, fev1, fei1, cap1};
    want = {1'b0, 5'd2, 1'b1, 4'd0, 16'h9235};
    total++;
    if (got !== want || done1 !== 1'b1) begin
      bad++;
      $display("FAIL s1_first_run: got %h done=%b want %h done=1", got, done1, want);
    end
    model1 = 16'h1234;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    got = {pass1, err1, fev1, fei1, cap1};
    total++;
    if (got !== 27'd0 || done1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL s1_restart_clear: res=%h done=%b busy=%b, want res=0 done=0 busy=1",
               got, done1, busy1);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({a1, b1, c1, d1} !== 4'(i) || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL s1_code%0d: abcd=%h busy=%b want abcd=%h busy=1",
                 i, {a1, b1, c1, d1}, busy1, 4'(i));
      end
      if (i == 15) begin
        @(posedge clk);
      end else begin
        repeat (2) @(posedge clk);
      end
      #1;
    end
    total++;
    if (done1 !== 1'b0) begin
      bad++;
      $display("FAIL s1_done_early: done=%b at start+32, want 0", done1);
    end
    @(posedge clk);
    #1;
    got  = {pass1, err1, fev1, fei1, cap1};
    want = {1'b1, 5'd0, 1'b0, 4'd0, 16'h1234};
    total++;
    if (done1 !== 1'b1 || got !== want) begin
      bad++;
      $display("FAIL s1_second_run: done=%b res=%h want done=1 res=%h", done1, got, want);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_single_mismatch();
    test_all_mismatch();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
